// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types and helpers for the parametrised up/down counter.
//   - cnt_mode_t      : boundary behaviour (wrap around or saturate)
//   - modulus_fits()  : elaboration-time check that a modulus is usable
//                       with a given register width
package counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_t;

  // True when 0..modulus-1 is a non-trivial range that fits in width bits.
  function automatic bit modulus_fits(input int width, input int modulus);
    return (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

endpackage : counter_pkg

// File: rtl/updown_counter_n.sv
// updown_counter_n
//   Up/down counter over 0..MODULUS-1 with wrap/saturate mode, count enable,
//   synchronous clamped parallel load, boundary flags and a registered wrap
//   pulse.
//
//   Parameters
//     WIDTH    : count register width
//     MODULUS  : count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   Ports
//     clk      : rising-edge clock
//     reset    : asynchronous active-high reset (count=0, wrap=0)
//     en       : count enable, one step per enabled cycle
//     up_down  : 1 = up, 0 = down
//     mode     : CNT_WRAP or CNT_SATURATE
//     load     : synchronous load, overrides en
//     load_val : value to load (clamped to MODULUS-1)
//     count    : registered count
//     at_max   : count == MODULUS-1
//     at_min   : count == 0
//     wrap     : registered one-cycle pulse after a wrapping step
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  cnt_mode_t        mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  if (!modulus_fits(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("updown_counter_n: MODULUS=%0d is not usable with WIDTH=%0d",
           MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg,  wrap_next;

  // Boundaries are detected by comparison before stepping, so a
  // non-power-of-two modulus never relies on natural register overflow.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_down) begin
        if (count_reg == MAX_VAL) begin
          if (mode == CNT_WRAP) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (count_reg == '0) begin
          if (mode == CNT_WRAP) begin
            count_next = MAX_VAL;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Flags decode the register only, so no input reaches an output
  // combinationally.
  assign count  = count_reg;
  assign wrap   = wrap_reg;
  assign at_max = (count_reg == MAX_VAL);
  assign at_min = (count_reg == '0);

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n
//   Directed self-checking bench for updown_counter_n with WIDTH=4,
//   MODULUS=10. Inputs change 1 time unit after a rising edge; outputs are
//   checked at the same point, well away from the next edge.
module tb_updown_counter_n;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_down;
  cnt_mode_t  mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       at_max;
  logic       at_min;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_down  (up_down),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .at_max   (at_max),
    .at_min   (at_min),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks count, wrap and both flags; flags follow from the expected count.
  task automatic chk_all(input string tag, input int exp_count, input bit exp_wrap);
    chk({tag, " count"}, 32'(count), 32'(exp_count));
    chk({tag, " wrap"}, 32'(wrap), 32'(exp_wrap));
    chk({tag, " at_max"}, 32'(at_max), 32'(exp_count == 9));
    chk({tag, " at_min"}, 32'(at_min), 32'(exp_count == 0));
    $display("%0t %s: count=%0d wrap=%0b at_max=%0b at_min=%0b",
             $time, tag, count, wrap, at_max, at_min);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b1; mode = CNT_WRAP;
    load = 1'b0; load_val = 4'd0;

    // Reset state
    tick();
    chk_all("reset", 0, 1'b0);
    reset = 1'b0;

    // 1: wrap-mode count up through the modulus
    en = 1'b1; up_down = 1'b1; mode = CNT_WRAP;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all($sformatf("up_wrap[%0d]", i), up_seq[i], up_seq[i] == 0);
    end

    // 2: from 0, count down with wrap
    load = 1'b1; load_val = 4'd0;
    tick();
    chk_all("load0", 0, 1'b0);
    load = 1'b0; up_down = 1'b0;
    tick();
    chk_all("down_wrap0", 9, 1'b1);
    tick();
    chk_all("down_wrap1", 8, 1'b0);

    // 3: saturate up from 8, then down from 1
    mode = CNT_SATURATE; up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("sat_up[%0d]", i), 9, 1'b0);
    end
    load = 1'b1; load_val = 4'd1;
    tick();
    chk_all("load1", 1, 1'b0);
    load = 1'b0; up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("sat_down[%0d]", i), 0, 1'b0);
    end

    // 4: load beats enable, and out-of-range loads clamp
    mode = CNT_WRAP; up_down = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    chk_all("load5_en", 5, 1'b0);
    load_val = 4'd9;
    tick();
    load = 1'b0;
    tick();
    chk_all("wrap_before_load", 0, 1'b1);
    load = 1'b1; load_val = 4'd14;
    tick();
    chk_all("load14_clamp", 9, 1'b0);
    load_val = 4'd15;
    tick();
    chk_all("load15_clamp", 9, 1'b0);

    // 5: asynchronous reset between edges
    load_val = 4'd7;
    tick();
    chk_all("load7", 7, 1'b0);
    load = 1'b0; en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst_cnt7", 0, 1'b0);
    reset = 1'b0;
    en = 1'b1; up_down = 1'b0; mode = CNT_WRAP;
    tick();
    chk_all("pre_rst_wrap", 9, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst_wrap", 0, 1'b0);
    up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("rst_hold[%0d]", i), 0, 1'b0);
    end
    reset = 1'b0;
    tick();
    chk_all("rst_release", 1, 1'b0);

    // 6: disabled counter ignores direction and mode changes
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; up_down = 1'b0;
    tick();
    chk_all("wrap_before_hold", 9, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_down = i[0];
      mode = i[1] ? CNT_SATURATE : CNT_WRAP;
      tick();
      chk_all($sformatf("hold[%0d]", i), 9, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_updown_counter_n
